mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/load_extend.sv | 20 ++
 rtl/mem_stage.sv | 83 ++++++++
 tb/tb_mem_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared opcodes, funct3 codes, FSM states and access checks for the memory stage
package mem_stage_pkg;
  localparam logic [6:0] I_type_ld = 7'b0000011;
  localparam logic [6:0] S_type = 7'b0100011;
  localparam logic [31:0] nop = 32'h0000_0013;
  localparam logic [2:0] F3_B = 3'd0;
  localparam logic [2:0] F3_H = 3'd1;
  localparam logic [2:0] F3_W = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic logic misaligned(input logic is_ld, input logic [2:0] f3, input logic [1:0] lane);
    logic bad;
    bad = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (!is_ld && f3[2]);
    return bad || (f3[1:0] == 2'b01 && lane[0]) || (f3 == F3_W && lane != 2'b00);
  endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: picks the lane byte/halfword out of a read word and sign- or zero-extends it
module load_extend import mem_stage_pkg::*; (
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0] b;
  logic [15:0] h;
  // lane select then extension by load width
  always_comb begin
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    result = funct3 == F3_B  ? {{24{b[7]}}, b} :
             funct3 == F3_H  ? {{16{h[15]}}, h} :
             funct3 == F3_W  ? rdata :
             funct3 == F3_BU ? {24'b0, b} :
             funct3 == F3_HU ? {16'b0, h} : '0;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage driving a single-outstanding req/ack data bus and the MA pipeline register
module mem_stage import mem_stage_pkg::*; (
  input  logic        clk1,
  input  logic        rst,
  input  logic [31:0] EX_PC,
  input  logic [31:0] EX_instruction,
  input  logic [31:0] EX_aluresult,
  input  logic [31:0] EX_op2,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic [31:0] MA_PC,
  output logic [31:0] MA_instruction,
  output logic [31:0] MA_aluresult,
  output logic [31:0] MA_ldresult,
  output logic        MA_misaligned
);
  logic [1:0] state;
  logic [2:0] f3;
  logic [1:0] lane;
  logic is_ld, is_st, mis, go;
  logic [31:0] wdata_n, ext, ld_buf;
  logic [3:0] wstrb_n;
  assign f3 = EX_instruction[14:12];
  assign lane = EX_aluresult[1:0];
  load_extend u_ext (.rdata(dmem_rdata), .lane(lane), .funct3(f3), .result(ext));
  // decode, store formatting and stall; EX is frozen while stalled so its fields stay valid through BUSY
  always_comb begin
    is_ld = EX_instruction[6:0] == I_type_ld;
    is_st = EX_instruction[6:0] == S_type;
    mis = (is_ld || is_st) && misaligned(is_ld, f3, lane);
    go = (is_ld || is_st) && !mis;
    wdata_n = f3[1:0] == 2'b00 ? {4{EX_op2[7:0]}} : f3[1:0] == 2'b01 ? {2{EX_op2[15:0]}} : EX_op2;
    wstrb_n = !is_st ? 4'b0000 : f3[1:0] == 2'b00 ? 4'b0001 << lane : f3[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
    mem_stall = (state == IDLE && go) || state == BUSY;
  end
  // bus FSM: launch registered request, wait for ack, buffer load data for one DONE cycle
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
      ld_buf <= '0;
    end else if (state == IDLE && go) begin
      state <= BUSY;
      dmem_req <= 1'b1;
      dmem_we <= is_st;
      dmem_addr <= {EX_aluresult[31:2], 2'b00};
      dmem_wdata <= wdata_n;
      dmem_wstrb <= wstrb_n;
    end else if (state == BUSY && dmem_ack) begin
      state <= DONE;
      dmem_req <= 1'b0;
      ld_buf <= dmem_we ? '0 : ext;
    end else if (state != IDLE && state != BUSY) begin
      state <= IDLE;
    end
  end
  // MA register: captures on every non-stalled IDLE edge and on DONE, holds otherwise
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      MA_PC <= '0;
      MA_instruction <= nop;
      MA_aluresult <= '0;
      MA_ldresult <= '0;
      MA_misaligned <= 1'b0;
    end else if ((state == IDLE && !go) || state == DONE) begin
      MA_PC <= EX_PC;
      MA_instruction <= EX_instruction;
      MA_aluresult <= EX_aluresult;
      MA_ldresult <= state == DONE ? ld_buf : '0;
      MA_misaligned <= state == IDLE && mis;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed self-checking bench for mem_stage against a behavioural model
module tb_mem_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  logic clk1 = 1'b0;
  logic rst;
  logic [31:0] EX_PC, EX_instruction, EX_aluresult, EX_op2;
  logic dmem_req, dmem_we, dmem_ack, mem_stall, MA_misaligned;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0] dmem_wstrb;
  logic [31:0] MA_PC, MA_instruction, MA_aluresult, MA_ldresult;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int o_cycles, o_stall, o_req;
  logic [31:0] o_addr, o_wdata, o_pc;
  logic [3:0] o_wstrb;
  logic o_we, o_hold_bad;

  mem_stage dut (
    .clk1(clk1), .rst(rst), .EX_PC(EX_PC), .EX_instruction(EX_instruction),
    .EX_aluresult(EX_aluresult), .EX_op2(EX_op2), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall), .MA_PC(MA_PC),
    .MA_instruction(MA_instruction), .MA_aluresult(MA_aluresult), .MA_ldresult(MA_ldresult),
    .MA_misaligned(MA_misaligned)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  function automatic logic [31:0] mk_ins(input logic [6:0] opc, input int f3);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = 3'(f3);
    r[6:0] = opc;
    return r;
  endfunction

  function automatic bit ref_bad(input bit ld, input int f3, input int lane);
    int size;
    size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : (f3 == 2) ? 4 : 0;
    if (size == 0 || (!ld && f3 >= 4)) return 1'b1;
    return (lane % size) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int lane, input logic [31:0] rd);
    longint v;
    v = longint'(rd >> (8 * lane));
    case (f3)
      0: begin v = v % 256; if (v >= 128) v -= 256; end
      1: begin v = v % 65536; if (v >= 32768) v -= 65536; end
      2: v = longint'(rd);
      4: v = v % 256;
      5: v = v % 65536;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] op2);
    return f3 == 0 ? op2[7:0] * 32'h0101_0101 : f3 == 1 ? op2[15:0] * 32'h0001_0001 : op2;
  endfunction

  function automatic logic [3:0] ref_wstrb(input int f3, input int lane);
    return f3 == 0 ? 4'(1 << lane) : f3 == 1 ? 4'(3 << lane) : 4'hF;
  endfunction

  // present one instruction in EX, act as the memory answering on the w-th request cycle, return at MA capture
  task automatic issue(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] op2, input logic [31:0] rdata, input int w);
    int busy;
    logic [31:0] pc0;
    o_pc = $urandom;
    EX_PC = o_pc;
    EX_instruction = ins;
    EX_aluresult = alu;
    EX_op2 = op2;
    dmem_rdata = rdata;
    pc0 = MA_PC;
    o_cycles = 0; o_stall = 0; o_req = 0; busy = 0; o_hold_bad = 0;
    o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk1);
      dmem_ack = 1'b0;
      o_cycles++;
      if (mem_stall) begin
        o_stall++;
        if (MA_PC !== pc0) o_hold_bad = 1'b1;
      end
      if (dmem_req) begin
        o_req++;
        busy++;
        o_addr = dmem_addr; o_wdata = dmem_wdata; o_wstrb = dmem_wstrb; o_we = dmem_we;
        if (busy == w) dmem_ack = 1'b1;
      end
      if (!mem_stall) break;
    end
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk1);
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, mem_stall, MA_PC, MA_aluresult, MA_ldresult, MA_misaligned} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wd=%h ws=%b stall=%b pc=%h alu=%h ld=%h mis=%b expected all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, mem_stall, MA_PC, MA_aluresult, MA_ldresult, MA_misaligned);
    end
    checks++;
    if (MA_instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h expected %h", MA_instruction, NOP); end
  endtask

  task automatic test_passthrough;
    logic [31:0] ins;
    ins = mk_ins(OP_IMM, 0);
    issue(ins, 32'h5, 32'h0, 32'h0, 1);
    checks++;
    if (MA_aluresult !== 32'h5) begin errors++; $display("FAIL addi_alu got %h expected 5", MA_aluresult); end
    checks++;
    if (o_req !== 0 || o_stall !== 0 || o_cycles !== 1) begin errors++; $display("FAIL addi_timing got req=%0d stall=%0d cyc=%0d expected 0 0 1", o_req, o_stall, o_cycles); end
    checks++;
    if (MA_instruction !== ins || MA_PC !== o_pc || MA_ldresult !== 0) begin errors++; $display("FAIL addi_regs got ins=%h pc=%h ld=%h expected %h %h 0", MA_instruction, MA_PC, MA_ldresult, ins, o_pc); end
  endtask

  task automatic test_lb;
    issue(mk_ins(OP_LD, 0), 32'h103, 32'h0, 32'h8012_3456, 2);
    checks++;
    if (MA_ldresult !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h expected ffffff80", MA_ldresult); end
    checks++;
    if (o_addr !== 32'h100 || o_we !== 1'b0 || o_wstrb !== 4'h0) begin errors++; $display("FAIL lb_bus got addr=%h we=%b ws=%b expected 100 0 0000", o_addr, o_we, o_wstrb); end
    checks++;
    if (o_stall !== 3 || o_req !== 2 || o_cycles !== 4) begin errors++; $display("FAIL lb_timing got stall=%0d req=%0d cyc=%0d expected 3 2 4", o_stall, o_req, o_cycles); end
    checks++;
    if (o_hold_bad !== 1'b0 || MA_PC !== o_pc) begin errors++; $display("FAIL lb_hold got hold_bad=%b pc=%h expected 0 %h", o_hold_bad, MA_PC, o_pc); end
  endtask

  task automatic test_lh;
    issue(mk_ins(OP_LD, 5), 32'h102, 32'h0, 32'hBEEF_1234, 1);
    checks++;
    if (MA_ldresult !== 32'h0000_BEEF || o_cycles !== 3) begin errors++; $display("FAIL lhu_data got %h cyc=%0d expected 0000beef 3", MA_ldresult, o_cycles); end
    issue(mk_ins(OP_LD, 1), 32'h102, 32'h0, 32'hBEEF_1234, 3);
    checks++;
    if (MA_ldresult !== 32'hFFFF_BEEF || o_cycles !== 5) begin errors++; $display("FAIL lh_data got %h cyc=%0d expected ffffbeef 5", MA_ldresult, o_cycles); end
  endtask

  task automatic test_store;
    issue(mk_ins(OP_ST, 0), 32'h201, 32'h1234_56AB, 32'hDEAD_BEEF, 1);
    checks++;
    if (o_wdata !== 32'hABAB_ABAB || o_wstrb !== 4'b0010 || o_we !== 1'b1 || o_addr !== 32'h200) begin
      errors++; $display("FAIL sb_bus got wd=%h ws=%b we=%b addr=%h expected abababab 0010 1 200", o_wdata, o_wstrb, o_we, o_addr);
    end
    checks++;
    if (MA_ldresult !== 0 || MA_aluresult !== 32'h201) begin errors++; $display("FAIL sb_ma got ld=%h alu=%h expected 0 201", MA_ldresult, MA_aluresult); end
    issue(mk_ins(OP_ST, 2), 32'h204, 32'hCAFE_F00D, 32'h0, 2);
    checks++;
    if (o_wstrb !== 4'hF || o_wdata !== 32'hCAFE_F00D || o_addr !== 32'h204) begin errors++; $display("FAIL sw_bus got ws=%b wd=%h addr=%h expected 1111 cafef00d 204", o_wstrb, o_wdata, o_addr); end
  endtask

  task automatic test_misaligned;
    issue(mk_ins(OP_LD, 2), 32'h102, 32'h0, 32'h1111_1111, 1);
    checks++;
    if (o_req !== 0 || o_cycles !== 1 || o_stall !== 0) begin errors++; $display("FAIL lw_mis_timing got req=%0d cyc=%0d stall=%0d expected 0 1 0", o_req, o_cycles, o_stall); end
    checks++;
    if (MA_misaligned !== 1'b1 || MA_ldresult !== 0) begin errors++; $display("FAIL lw_mis_ma got mis=%b ld=%h expected 1 0", MA_misaligned, MA_ldresult); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int kind, f3, lane, w;
      bit ld, bad;
      logic [31:0] ins, alu, op2, rd, exp_ld;
      kind = $urandom_range(0, 2);
      f3 = $urandom_range(0, 7);
      if (f3 >= 3 && $urandom_range(0, 2) != 0) f3 = $urandom_range(0, 2);
      alu = $urandom; op2 = $urandom; rd = $urandom;
      w = $urandom_range(1, 4);
      lane = int'(alu[1:0]);
      ld = kind == 0;
      ins = mk_ins(kind == 0 ? OP_LD : kind == 1 ? OP_ST : OP_IMM, f3);
      bad = kind != 2 && ref_bad(ld, f3, lane);
      exp_ld = (ld && !bad) ? ref_load(f3, lane, rd) : 32'h0;
      issue(ins, alu, op2, rd, w);
      checks++;
      if (MA_PC !== o_pc || MA_instruction !== ins || MA_aluresult !== alu || o_hold_bad) begin
        errors++; $display("FAIL rnd_pass n=%0d got pc=%h ins=%h alu=%h hold_bad=%b expected %h %h %h 0", n, MA_PC, MA_instruction, MA_aluresult, o_hold_bad, o_pc, ins, alu);
      end
      checks++;
      if (MA_ldresult !== exp_ld || MA_misaligned !== bad) begin
        errors++; $display("FAIL rnd_result n=%0d ins=%h alu=%h rd=%h got ld=%h mis=%b expected %h %b", n, ins, alu, rd, MA_ldresult, MA_misaligned, exp_ld, bad);
      end
      checks++;
      if (kind == 2 || bad) begin
        if (o_req !== 0 || o_cycles !== 1) begin errors++; $display("FAIL rnd_nobus n=%0d got req=%0d cyc=%0d expected 0 1", n, o_req, o_cycles); end
      end else if (o_req !== w || o_cycles !== 2 + w || o_addr !== (alu & 32'hFFFF_FFFC) || o_we !== !ld ||
                   o_wstrb !== (ld ? 4'h0 : ref_wstrb(f3, lane)) || (!ld && o_wdata !== ref_wdata(f3, op2))) begin
        errors++; $display("FAIL rnd_bus n=%0d ins=%h alu=%h got req=%0d cyc=%0d addr=%h we=%b ws=%b wd=%h expected w=%0d", n, ins, alu, o_req, o_cycles, o_addr, o_we, o_wstrb, o_wdata, w);
      end
    end
  endtask

  task automatic test_back_to_back;
    int c0, total;
    logic [31:0] rd, exp;
    c0 = cyc; total = 0;
    for (int n = 0; n < 5; n++) begin
      int w;
      w = $urandom_range(1, 3);
      rd = $urandom;
      exp = rd;
      issue(mk_ins(OP_LD, 2), $urandom & 32'hFFFF_FFFC, 32'h0, rd, w);
      total += 2 + w;
      checks++;
      if (MA_ldresult !== exp) begin errors++; $display("FAIL b2b_data n=%0d got %h expected %h", n, MA_ldresult, exp); end
    end
    checks++;
    if (cyc - c0 !== total) begin errors++; $display("FAIL b2b_cycles got %0d expected %0d", cyc - c0, total); end
  endtask

  task automatic test_reset_busy;
    EX_instruction = mk_ins(OP_LD, 0);
    EX_aluresult = 32'h300;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk1);
    @(negedge clk1);
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstbusy_req_before got %b expected 1", dmem_req); end
    rst = 1'b1;
    EX_instruction = NOP;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL rstbusy_drop got req=%b stall=%b expected 0 0", dmem_req, mem_stall); end
    @(negedge clk1);
    rst = 1'b0;
    @(negedge clk1);
    dmem_ack = 1'b1;
    @(negedge clk1);
    dmem_ack = 1'b0;
    checks++;
    if (MA_ldresult !== 0 || dmem_req !== 1'b0 || MA_instruction !== NOP || mem_stall !== 1'b0) begin
      errors++; $display("FAIL rstbusy_stray_ack got ld=%h req=%b ins=%h stall=%b expected 0 0 %h 0", MA_ldresult, dmem_req, MA_instruction, mem_stall, NOP);
    end
  endtask

  initial begin
    rst = 1'b1;
    EX_PC = '0; EX_instruction = NOP; EX_aluresult = '0; EX_op2 = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    @(negedge clk1);
    test_reset;
    rst = 1'b0;
    @(posedge clk1);
    #1;
    test_passthrough;
    test_lb;
    test_lh;
    test_store;
    test_misaligned;
    test_random;
    test_back_to_back;
    test_reset_busy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
